// File: rtl/alu_op_scheduler_if.sv
// alu_op_scheduler_if
//   Bundles every handshake and bus signal between the operation scheduler,
//   its two requesters and the hierarchical ALU.
//
//   Signals:
//     req0_* / req1_*  requester valid/ready handshake plus function code and operands
//     ALU_FUN          function code driven into the ALU
//     alu_a, alu_b     operands driven into the ALU
//     unit_en          one-hot ALU unit enable
//     alu_result       result returned by the ALU
//     rsp_valid/id/data  one-cycle response pulse, issuing requester and result
//     busy             scheduler is not idle
//
//   Modports:
//     master  requesters, ALU and response consumer (the scheduler's environment)
//     slave   the scheduler itself
interface alu_op_scheduler_if #(
  parameter int DATA_W = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic [3:0]        req0_fun;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [3:0]        req1_fun;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [3:0]        ALU_FUN;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        unit_en;
  logic [DATA_W-1:0] alu_result;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  modport master (
    output req0_valid, req0_fun, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_fun, req1_a, req1_b,
    input  req1_ready,
    input  ALU_FUN, alu_a, alu_b, unit_en,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req0_valid, req0_fun, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_fun, req1_a, req1_b,
    output req1_ready,
    output ALU_FUN, alu_a, alu_b, unit_en,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
//   Sequencer and arbiter in front of the hierarchical ALU. Two requesters
//   submit operations over valid/ready; one is granted at a time, its
//   function code and operands are driven into the ALU for LAT cycles, then
//   the ALU result is captured and returned with the winner's ID.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   alu_op_scheduler_if.slave (requester handshakes, ALU drive,
//           ALU result, response pulse, busy)
//
//   Parameters:
//     DATA_W  operand/result width (must match the interface instance)
//     LAT     ALU cycles from enable to valid result, 1..15
//
//   Build option:
//     ALU_SCHED_FIXED_PRIO_EN  when defined, requester 0 always wins a
//                              conflict; otherwise round-robin arbitration.
module alu_op_scheduler #(
  parameter int DATA_W = 16,
  parameter int LAT    = 2
) (
  input logic              clk,
  input logic              rst,
  alu_op_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        fun_q, fun_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              id_q, id_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
  logic              last_grant_q, last_grant_d;
`endif

  logic grant_valid;
  logic grant_id;
  logic accept;

  // Arbitration: pick a winner among the valid requesters. On a conflict
  // the round-robin build favours whoever was not granted last time.
  always_comb begin
    grant_valid = bus.req0_valid || bus.req1_valid;
    grant_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      grant_id = 1'b0;
`else
      grant_id = ~last_grant_q;
`endif
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Ready is combinational so a transfer completes in the same IDLE cycle
  // the winner is chosen; rst masks it so nothing is accepted during reset.
  always_comb begin
    accept         = (state_q == IDLE) && !rst && grant_valid;
    bus.req0_ready = accept && !grant_id;
    bus.req1_ready = accept && grant_id;
  end

  // Next-state logic: latch the granted operation, count down the ALU
  // latency, capture the result on the final EXEC cycle, pulse the response.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fun_d      = fun_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          cnt_d   = CNT_INIT;
          id_d    = grant_id;
          fun_d   = grant_id ? bus.req1_fun : bus.req0_fun;
          a_d     = grant_id ? bus.req1_a   : bus.req0_a;
          b_d     = grant_id ? bus.req1_b   : bus.req0_b;
`ifndef ALU_SCHED_FIXED_PRIO_EN
          last_grant_d = grant_id;
`endif
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          rsp_data_d = bus.alu_result;
          rsp_id_d   = id_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ALU drive and response outputs. Operands simply follow the latched
  // values so they keep their last value outside EXEC; function code and
  // unit enables are only presented while the ALU is actually executing.
  always_comb begin
    bus.ALU_FUN = 4'd0;
    bus.unit_en = 4'd0;
    if (state_q == EXEC) begin
      bus.ALU_FUN = fun_q;
      unique case (fun_q[3:2])
        2'b00:   bus.unit_en = 4'b1000;
        2'b01:   bus.unit_en = 4'b0100;
        2'b10:   bus.unit_en = 4'b0010;
        default: bus.unit_en = 4'b0001;
      endcase
    end
    bus.alu_a     = a_q;
    bus.alu_b     = b_q;
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_id    = rsp_id_q;
    bus.rsp_data  = rsp_data_q;
    bus.busy      = (state_q != IDLE);
  end

  // State register. Reset aborts any in-flight operation and re-arms the
  // arbiter so requester 0 wins the first conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      fun_q      <= 4'd0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fun_q      <= fun_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler
//   Self-checking bench for alu_op_scheduler. Two requester queues drive the
//   handshakes, a behavioural ALU answers on alu_result, and a cycle model
//   of the expected scheduler phases plus a result scoreboard check every
//   output on each falling edge. Honours ALU_SCHED_FIXED_PRIO_EN.
module tb_alu_op_scheduler;

  localparam int LAT = 2;

  typedef struct packed {
    logic [3:0]  fun;
    logic [15:0] a;
    logic [15:0] b;
  } op_t;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic rst;

  alu_op_scheduler_if #(.DATA_W(16)) sched_bus ();

  alu_op_scheduler #(.DATA_W(16), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sched_bus)
  );

  int vec_count = 0;
  int err_count = 0;
  int cyc       = 0;

  op_t  pend0[$];
  op_t  pend1[$];
  exp_t sb[$];
  logic grant_log[$];
  int   hs_cycles[$];

  int          exec_left  = 0;
  logic        rsp_due    = 1'b0;
  logic        m_last     = 1'b1;
  logic [3:0]  m_fun      = 4'd0;
  logic [15:0] m_a        = 16'd0;
  logic [15:0] m_b        = 16'd0;
  logic        m_rsp_id   = 1'b0;
  logic [15:0] m_rsp_data = 16'd0;

  // Behavioural ALU: op selects the arithmetic, unit flips high result bits
  // so a wrong unit/function routing shows up in the data.
  function automatic logic [15:0] alu_model(logic [3:0] fun, logic [15:0] a, logic [15:0] b);
    logic [15:0] r;
    logic [1:0]  u;
    case (fun[1:0])
      2'b00:   r = a - b;
      2'b01:   r = a & b;
      2'b10:   r = a + b;
      default: r = a | b;
    endcase
    u = fun[3:2] ^ 2'b01;
    return r ^ {u, 14'h0};
  endfunction

  function automatic logic [3:0] unit_decode(logic [3:0] fun);
    case (fun[3:2])
      2'b00:   return 4'b1000;
      2'b01:   return 4'b0100;
      2'b10:   return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  assign sched_bus.alu_result = alu_model(sched_bus.ALU_FUN, sched_bus.alu_a, sched_bus.alu_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(string tag, logic [31:0] actual, logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, actual, expected);
    end
  endtask

  // Present the head of each requester queue; valid stays high while the
  // queue is non-empty so an ungranted requester holds valid and data.
  task automatic driveReqs();
    sched_bus.req0_valid = (pend0.size() != 0);
    sched_bus.req1_valid = (pend1.size() != 0);
    if (pend0.size() != 0) begin
      sched_bus.req0_fun = pend0[0].fun;
      sched_bus.req0_a   = pend0[0].a;
      sched_bus.req0_b   = pend0[0].b;
    end
    if (pend1.size() != 0) begin
      sched_bus.req1_fun = pend1[0].fun;
      sched_bus.req1_a   = pend1[0].a;
      sched_bus.req1_b   = pend1[0].b;
    end
  endtask

  task automatic applyStimulus(logic id, logic [3:0] fun, logic [15:0] a, logic [15:0] b);
    op_t op;
    op.fun = fun;
    op.a   = a;
    op.b   = b;
    if (id) pend1.push_back(op);
    else    pend0.push_back(op);
    driveReqs();
  endtask

  // One clock cycle: compare all outputs against the phase model at the
  // falling edge, advance the model, then update the drivers after the
  // rising edge.
  task automatic stepCycle();
    logic v0, v1, idle, exp_r0, exp_r1, hs0, hs1, in_exec;
    exp_t e;
    op_t  op;
    @(negedge clk);
    v0      = (pend0.size() != 0);
    v1      = (pend1.size() != 0);
    idle    = (exec_left == 0) && !rsp_due;
    in_exec = (exec_left > 0);
    exp_r0  = 1'b0;
    exp_r1  = 1'b0;
    if (idle && !rst) begin
      if (v0 && v1) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
        exp_r0 = 1'b1;
`else
        exp_r0 = m_last;
        exp_r1 = !m_last;
`endif
      end else begin
        exp_r0 = v0;
        exp_r1 = v1;
      end
    end
    if (rsp_due) begin
      if (sb.size() == 0) begin
        checkOutput("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        e          = sb.pop_front();
        m_rsp_id   = e.id;
        m_rsp_data = e.data;
      end
    end
    checkOutput("req0_ready", 32'(sched_bus.req0_ready), 32'(exp_r0));
    checkOutput("req1_ready", 32'(sched_bus.req1_ready), 32'(exp_r1));
    checkOutput("busy",       32'(sched_bus.busy),       32'(!idle));
    checkOutput("rsp_valid",  32'(sched_bus.rsp_valid),  32'(rsp_due));
    checkOutput("rsp_id",     32'(sched_bus.rsp_id),     32'(m_rsp_id));
    checkOutput("rsp_data",   32'(sched_bus.rsp_data),   32'(m_rsp_data));
    checkOutput("alu_a",      32'(sched_bus.alu_a),      32'(m_a));
    checkOutput("alu_b",      32'(sched_bus.alu_b),      32'(m_b));
    checkOutput("unit_en",    32'(sched_bus.unit_en),    in_exec ? 32'(unit_decode(m_fun)) : 32'd0);
    checkOutput("ALU_FUN",    32'(sched_bus.ALU_FUN),    in_exec ? 32'(m_fun) : 32'd0);

    hs0 = v0 && (sched_bus.req0_ready === 1'b1);
    hs1 = v1 && (sched_bus.req1_ready === 1'b1) && !hs0;

    if (exec_left > 0) begin
      exec_left--;
      if (exec_left == 0) rsp_due = 1'b1;
    end else if (rsp_due) begin
      rsp_due = 1'b0;
    end
    if (hs0 || hs1) begin
      op        = hs0 ? pend0[0] : pend1[0];
      e.id      = hs1;
      e.data    = alu_model(op.fun, op.a, op.b);
      sb.push_back(e);
      m_fun     = op.fun;
      m_a       = op.a;
      m_b       = op.b;
      exec_left = LAT;
      m_last    = hs1;
      grant_log.push_back(hs1);
      hs_cycles.push_back(cyc);
    end
    if (rst) begin
      exec_left  = 0;
      rsp_due    = 1'b0;
      m_last     = 1'b1;
      m_fun      = 4'd0;
      m_a        = 16'd0;
      m_b        = 16'd0;
      m_rsp_id   = 1'b0;
      m_rsp_data = 16'd0;
      sb.delete();
    end
    @(posedge clk);
    cyc++;
    #1;
    if (hs0) void'(pend0.pop_front());
    if (hs1) void'(pend1.pop_front());
    driveReqs();
  endtask

  task automatic runUntilIdle(int budget);
    int n;
    n = 0;
    while ((pend0.size() != 0 || pend1.size() != 0 || exec_left != 0 || rsp_due) && n < budget) begin
      stepCycle();
      n++;
    end
    if (pend0.size() != 0 || pend1.size() != 0 || exec_left != 0 || rsp_due)
      checkOutput("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic exp_seq[4];
    int   start;
    int   n;

    sched_bus.req0_valid = 1'b0;
    sched_bus.req1_valid = 1'b0;
    sched_bus.req0_fun   = 4'd0;
    sched_bus.req0_a     = 16'd0;
    sched_bus.req0_b     = 16'd0;
    sched_bus.req1_fun   = 4'd0;
    sched_bus.req1_a     = 16'd0;
    sched_bus.req1_b     = 16'd0;

    // Reset held two checked cycles with both requesters valid; the first
    // cycle after release must grant requester 0 (fun 0110, 5+3 = 0008).
    rst = 1'b1;
    applyStimulus(1'b0, 4'b0110, 16'd5, 16'd3);
    applyStimulus(1'b1, 4'b1101, 16'h00F0, 16'h0F0F);
    @(posedge clk);
    cyc++;
    #1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    grant_log.delete();
    hs_cycles.delete();
    runUntilIdle(50);
    checkOutput("first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 1'bx), 32'd0);
    checkOutput("first_rsp_data", 32'(alu_model(4'b0110, 16'd5, 16'd3)), 32'h0008);

    // Unit decode across all four unit selects.
    applyStimulus(1'b0, 4'b0000, 16'h1234, 16'h0034);
    applyStimulus(1'b0, 4'b0101, 16'hFF0F, 16'h0FF0);
    applyStimulus(1'b0, 4'b1010, 16'h7FFF, 16'h0001);
    applyStimulus(1'b0, 4'b1111, 16'hA000, 16'h000A);
    runUntilIdle(60);

    // Both requesters continuously valid after a fresh reset.
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    grant_log.delete();
    hs_cycles.delete();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'(i), 16'(100 + i), 16'(7 * i));
      applyStimulus(1'b1, 4'(8 + i), 16'(200 + i), 16'(3 * i));
    end
`ifdef ALU_SCHED_FIXED_PRIO_EN
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    runUntilIdle(200);
    if (grant_log.size() < 4) begin
      checkOutput("rr_grant_count", 32'(grant_log.size()), 32'd4);
    end else begin
      for (int i = 0; i < 4; i++) checkOutput("rr_grant_seq", 32'(grant_log[i]), 32'(exp_seq[i]));
      for (int i = 0; i < 3; i++) checkOutput("rr_spacing", 32'(hs_cycles[i+1] - hs_cycles[i]), 32'(LAT + 2));
    end

    // Reset asserted in the second EXEC cycle aborts the operation.
    start = grant_log.size();
    applyStimulus(1'b0, 4'b1001, 16'h5555, 16'h00AA);
    n = 0;
    while (grant_log.size() == start && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("abort_handshake_seen", 32'(grant_log.size() - start), 32'd1);
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    stepCycle();
    stepCycle();
    stepCycle();
    applyStimulus(1'b1, 4'b0011, 16'h0C0C, 16'h3030);
    runUntilIdle(50);

    // Random traffic from both requesters with random gaps.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), 16'($urandom));
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) stepCycle();
    end
    runUntilIdle(300);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
# alu_op_scheduler

Sequencer and arbiter in front of the hierarchical ALU. Two requesters submit operations (4-bit function code plus two operands) over valid/ready handshakes. The block grants one requester at a time and drives the ALU function code, operands and one-hot unit enables for a fixed execution latency. It then captures the ALU result and returns it with the winning requester's ID. It sits between the command sources and the ALU top, replacing direct drive of ALU_FUN.

## Interface

Parameters:
- DATA_W, 16, operand/result width
- LAT, 2, ALU cycles from enable to valid result; legal range 1..15

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_fun  in  4  requester 0 function code; [3:2] unit select, [1:0] op within unit
- req0_a, req0_b  in  DATA_W  requester 0 operands
- req1_valid, req1_ready, req1_fun, req1_a, req1_b  same as requester 0, for requester 1
- ALU_FUN  out  4  function code to ALU
- alu_a, alu_b  out  DATA_W  operands to ALU
- unit_en  out  4  one-hot unit enable
- alu_result  in  DATA_W  ALU output
- rsp_valid  out  1  one-cycle pulse, result available
- rsp_id  out  1  requester that issued the result
- rsp_data  out  DATA_W  captured result
- busy  out  1  high whenever state is not IDLE

## Operation

- FSM states and transitions:
  - IDLE: waits for a request. Any reqN_valid → grant and move to EXEC.
  - EXEC: counter loaded with LAT-1 on entry, decrements each cycle. At 0, captures alu_result into rsp_data and moves to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then returns to IDLE.
- Handshake:
  - reqN_ready is combinational: high only in IDLE and only for the granted requester.
  - Transfer occurs when reqN_valid && reqN_ready.
  - On transfer, fun, a, b and the ID are latched.
  - The ungranted requester sees ready=0 and must hold its valid and data.
- Arbitration: round-robin via a last_grant register.
  - Only one requester valid → that requester wins.
  - Both valid → the requester not in last_grant wins.
  - last_grant updates on every grant.
- Unit decode, from latched fun[3:2]: 00→1000, 01→0100, 10→0010, 11→0001.
- Outputs during EXEC: unit_en, ALU_FUN, alu_a and alu_b hold the latched values.
- Outputs outside EXEC: unit_en=0 and ALU_FUN=0. alu_a and alu_b hold their last values.
- rsp_id and rsp_data hold their values after RESP until the next capture.
- There is no response backpressure; consumers must accept the rsp_valid pulse.
- New requests are not accepted during EXEC or RESP.

## Timing

- Reset values:
  - state IDLE; last_grant=1, so requester 0 wins the first conflict.
  - ALU_FUN=0, alu_a=0, alu_b=0, unit_en=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req0_ready and req1_ready are 0 during reset.
- Per operation, with the handshake in cycle T:
  - unit_en active in cycles T+1..T+LAT.
  - alu_result sampled at the end of cycle T+LAT.
  - rsp_valid high in cycle T+LAT+1.
  - Earliest next handshake is cycle T+LAT+2.
  - Throughput: one operation per LAT+2 cycles.
- Reset mid-operation (rst high in EXEC or RESP):
  - The operation is aborted and no rsp_valid is produced.
  - All outputs return to reset values on the next edge.
  - last_grant returns to 1.
- A request arriving while busy is not lost; it is served in the first IDLE cycle.

## Configuration

- ALU_SCHED_FIXED_PRIO_EN:
  - Defined: fixed priority; requester 0 always wins a conflict and last_grant is unused.
  - Undefined (default): round-robin as described above.
  - All other behaviour is identical in both builds.

## Test plan

- Reset: hold rst 2 cycles with both valids high → all outputs 0 and both readys 0. On the first cycle after reset release, req0_ready=1.
- Single op, LAT=2: req0 sends fun=4'b0110, a=5, b=3; bench ALU model returns 16'h0008.
  - unit_en=0100 and ALU_FUN=0110 for cycles T+1 and T+2.
  - rsp_valid=1 with rsp_id=0 and rsp_data=16'h0008 at T+3.
  - busy falls at T+4.
- Unit decode: fun[3:2]=00, 01, 10, 11 → unit_en=1000, 0100, 0010, 0001 respectively.
- Round-robin: both requesters valid continuously for 4 operations → grant sequence 0,1,0,1, with handshakes spaced exactly LAT+2 cycles apart.
- Fixed priority (ALU_SCHED_FIXED_PRIO_EN defined), same stimulus as round-robin → grant sequence 0,0,0,0 and req1_ready never asserted.
- Reset mid-op: assert rst in the second EXEC cycle → unit_en=0 on the next edge, no rsp_valid ever produced for that operation, and the next request is accepted normally.
